// File: rtl/uart_rx_buffer_if.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_buffer_if : receiver-side and datapath-side signals of the   |
// | UART receive buffer. Revision 1.0                                    |
// +----------------------------------------------------------------------+
interface uart_rx_buffer_if #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
);
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ready;
  logic        DataOutReady;
  logic        Stall;
  logic [7:0]  DataOut;
  logic        DataOutValid;
  logic [AW:0] count;
  logic        overrun;
  logic [7:0]  drop_count;
  logic        clr_status;

  // Driving side: UART receiver plus CPU datapath.
  modport master (
    output rx_data, rx_valid, DataOutReady, Stall, clr_status,
    input  rx_ready, DataOut, DataOutValid, count, overrun, drop_count
  );

  modport slave (
    input  rx_data, rx_valid, DataOutReady, Stall, clr_status,
    output rx_ready, DataOut, DataOutValid, count, overrun, drop_count
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | uart_rx_buffer : first-word-fall-through receive byte FIFO with      |
// | sticky overrun flag and saturating drop counter. Revision 1.0        |
// +----------------------------------------------------------------------+
module uart_rx_buffer #(
  parameter int DEPTH = 8,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic            CLK,
  input  logic            reset,
  uart_rx_buffer_if.slave bus
);

  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [7:0]    mem_q [DEPTH];
  logic [AW-1:0] wp_q, wp_d;
  logic [AW-1:0] rp_q, rp_d;
  logic [AW:0]   count_q, count_d;
  logic          overrun_q, overrun_d;
  logic [7:0]    drop_q, drop_d;

  logic full, empty, push, pop, drop;

  assign full  = (count_q == CNT_FULL);
  assign empty = (count_q == '0);
  // Space freed by a same-cycle pop is deliberately not offered to a push.
  assign push  = bus.rx_valid & ~full & reset;
  assign pop   = bus.DataOutReady & ~empty & ~bus.Stall;
  assign drop  = bus.rx_valid & full;

  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    count_d   = count_q;
    overrun_d = overrun_q;
    drop_d    = drop_q;

    if (push) wp_d = wp_q + AW'(1);
    if (pop)  rp_d = rp_q + AW'(1);

    if (push && !pop)      count_d = count_q + (AW+1)'(1);
    else if (pop && !push) count_d = count_q - (AW+1)'(1);

    if (bus.clr_status) begin
      overrun_d = 1'b0;
      drop_d    = 8'h00;
    end else if (drop) begin
      overrun_d = 1'b1;
      if (drop_q != 8'hFF) drop_d = drop_q + 8'h01;
    end
  end

  always_ff @(posedge CLK) begin
    if (!reset) begin
      wp_q      <= '0;
      rp_q      <= '0;
      count_q   <= '0;
      overrun_q <= 1'b0;
      drop_q    <= 8'h00;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      count_q   <= count_d;
      overrun_q <= overrun_d;
      drop_q    <= drop_d;
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem_q[wp_q] <= bus.rx_data;
  end

  assign bus.rx_ready     = ~full & reset;
  assign bus.DataOutValid = ~empty;
  assign bus.DataOut      = empty ? 8'h00 : mem_q[rp_q];
  assign bus.count        = count_q;
  assign bus.overrun      = overrun_q;
  assign bus.drop_count   = drop_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_buffer.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_uart_rx_buffer : directed self-checking bench for uart_rx_buffer. |
// | Revision 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_uart_rx_buffer;

  localparam int DEPTH = 8;

  logic clk = 1'b0;
  logic reset;
  int   n_assert = 0;
  int   n_fail   = 0;

  always #5 clk = ~clk;

  uart_rx_buffer_if #(.DEPTH(DEPTH)) bus ();

  uart_rx_buffer #(.DEPTH(DEPTH)) dut (
    .CLK   (clk),
    .reset (reset),
    .bus   (bus)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    bus.rx_data  = b;
    bus.rx_valid = 1'b1;
    tick();
    bus.rx_valid = 1'b0;
  endtask

  // Checks the head byte while the read-enable is high, then pops it.
  task automatic pop_expect(input string tag, input logic [7:0] b);
    bus.DataOutReady = 1'b1;
    #1;
    check(tag, {8'h00, bus.DataOut}, {8'h00, b});
    tick();
    bus.DataOutReady = 1'b0;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset            = 1'b0;
    bus.rx_data      = 8'h00;
    bus.rx_valid     = 1'b0;
    bus.DataOutReady = 1'b0;
    bus.Stall        = 1'b0;
    bus.clr_status   = 1'b0;

    // Reset / basic
    tick(); tick();
    check("rst_rx_ready", 16'(bus.rx_ready), 16'h0);
    check("rst_valid",    16'(bus.DataOutValid), 16'h0);
    check("rst_dataout",  16'(bus.DataOut), 16'h0);
    check("rst_count",    16'(bus.count), 16'h0);
    check("rst_overrun",  16'(bus.overrun), 16'h0);
    check("rst_drops",    16'(bus.drop_count), 16'h0);
    reset = 1'b1;
    #1;
    check("rel_rx_ready", 16'(bus.rx_ready), 16'h1);
    push(8'h41);
    check("basic_data",  16'(bus.DataOut), 16'h41);
    check("basic_valid", 16'(bus.DataOutValid), 16'h1);
    check("basic_count", 16'(bus.count), 16'h1);
    pop_expect("basic_pop", 8'h41);
    check("basic_empty_valid", 16'(bus.DataOutValid), 16'h0);
    check("basic_empty_data",  16'(bus.DataOut), 16'h0);
    check("basic_empty_count", 16'(bus.count), 16'h0);

    // Ordering and pointer wrap
    for (int i = 1; i <= 8; i++) push(8'(i));
    check("wrap_full_count", 16'(bus.count), 16'd8);
    check("wrap_full_ready", 16'(bus.rx_ready), 16'h0);
    for (int i = 1; i <= 3; i++) pop_expect("wrap_pop_a", 8'(i));
    for (int i = 9; i <= 11; i++) push(8'(i));
    for (int i = 4; i <= 11; i++) pop_expect("wrap_pop_b", 8'(i));
    check("wrap_count0",  16'(bus.count), 16'h0);
    check("wrap_overrun", 16'(bus.overrun), 16'h0);

    // Overrun and clear
    for (int i = 0; i < 8; i++) push(8'hA0 + 8'(i));
    bus.rx_data  = 8'hEE;
    bus.rx_valid = 1'b1;
    tick(); tick(); tick();
    bus.rx_valid = 1'b0;
    check("ovr_flag",  16'(bus.overrun), 16'h1);
    check("ovr_drops", 16'(bus.drop_count), 16'd3);
    check("ovr_count", 16'(bus.count), 16'd8);
    check("ovr_head",  16'(bus.DataOut), 16'hA0);
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;
    check("clr_flag",  16'(bus.overrun), 16'h0);
    check("clr_drops", 16'(bus.drop_count), 16'h0);
    check("clr_count", 16'(bus.count), 16'd8);
    // Clear beats a concurrent overrun
    bus.rx_data    = 8'hEE;
    bus.rx_valid   = 1'b1;
    bus.clr_status = 1'b1;
    tick();
    bus.rx_valid   = 1'b0;
    bus.clr_status = 1'b0;
    check("clrwin_flag",  16'(bus.overrun), 16'h0);
    check("clrwin_drops", 16'(bus.drop_count), 16'h0);
    // Saturation of the drop counter
    bus.rx_valid = 1'b1;
    for (int i = 0; i < 260; i++) tick();
    bus.rx_valid = 1'b0;
    check("sat_drops", 16'(bus.drop_count), 16'h00FF);
    check("sat_flag",  16'(bus.overrun), 16'h1);
    for (int i = 0; i < 8; i++) pop_expect("ovr_contents", 8'hA0 + 8'(i));
    bus.clr_status = 1'b1;
    tick();
    bus.clr_status = 1'b0;

    // Stall gating
    push(8'h11);
    push(8'h22);
    bus.DataOutReady = 1'b1;
    bus.Stall        = 1'b1;
    tick(); tick(); tick();
    check("stall_hold_count", 16'(bus.count), 16'd2);
    bus.Stall = 1'b0;
    tick();
    bus.DataOutReady = 1'b0;
    check("stall_count", 16'(bus.count), 16'd1);
    check("stall_head",  16'(bus.DataOut), 16'h22);
    pop_expect("stall_drain", 8'h22);

    // Simultaneous push and pop
    for (int i = 0; i < 4; i++) push(8'h30 + 8'(i));
    bus.rx_data      = 8'h55;
    bus.rx_valid     = 1'b1;
    bus.DataOutReady = 1'b1;
    tick();
    bus.rx_valid     = 1'b0;
    bus.DataOutReady = 1'b0;
    check("pp_count", 16'(bus.count), 16'd4);
    check("pp_head",  16'(bus.DataOut), 16'h31);
    pop_expect("pp_order", 8'h31);
    pop_expect("pp_order", 8'h32);
    pop_expect("pp_order", 8'h33);
    pop_expect("pp_order", 8'h55);
    bus.rx_data      = 8'h55;
    bus.rx_valid     = 1'b1;
    bus.DataOutReady = 1'b1;
    tick();
    bus.rx_valid     = 1'b0;
    bus.DataOutReady = 1'b0;
    check("pp_empty_count", 16'(bus.count), 16'd1);
    check("pp_empty_head",  16'(bus.DataOut), 16'h55);
    pop_expect("pp_empty_drain", 8'h55);

    // Reset mid-operation
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    bus.rx_valid = 1'b1;
    tick(); tick();
    bus.rx_valid = 1'b0;
    for (int i = 0; i < 3; i++) pop_expect("mid_pop", 8'hC0 + 8'(i));
    check("mid_pre_count", 16'(bus.count), 16'd5);
    check("mid_pre_flag",  16'(bus.overrun), 16'h1);
    check("mid_pre_drops", 16'(bus.drop_count), 16'd2);
    reset        = 1'b0;
    bus.rx_data  = 8'h77;
    bus.rx_valid = 1'b1;
    tick();
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    #1;
    check("mid_count", 16'(bus.count), 16'h0);
    check("mid_valid", 16'(bus.DataOutValid), 16'h0);
    check("mid_data",  16'(bus.DataOut), 16'h0);
    check("mid_flag",  16'(bus.overrun), 16'h0);
    check("mid_drops", 16'(bus.drop_count), 16'h0);
    tick();
    check("mid_nostore", 16'(bus.count), 16'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
